div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Sequential signed 32-bit divider (MIPS DIV semantics), one quotient bit per cycle.
//  Responder to the control unit's div start/stop handshake: control raises div_control, block answers with div_stop.
//  Sits beside the A/B registers; drives HI/LO candidates into the hi/lo select muxes.
//  Flags divide-by-zero so control can take the exception path.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  reset        in   1      synchronous, active-high
//  div_control  in   1      start request; sampled only in IDLE
//  a_in         in   WIDTH  dividend (A register output)
//  b_in         in   WIDTH  divisor (B register output)
//  hi_out       out  WIDTH  remainder
//  lo_out       out  WIDTH  quotient
//  div_zero     out  1      divisor was zero; 1-cycle pulse, coincident with div_stop
//  div_stop     out  1      operation finished; 1-cycle pulse
// BEHAVIOUR
//  Interface: one clock; reset synchronous, active-high; ports clk/reset.
//  Reset: state=IDLE, hi_out=0, lo_out=0, div_zero=0, div_stop=0, counter=0; aborts any operation in progress.
//  States: IDLE -> RUN -> FIX -> DONE -> IDLE; IDLE -> ZERO -> IDLE.
//  IDLE: on div_control=1, latch a_in, b_in, sign_q=a[31]^b[31], sign_r=a[31].
//   b_in==0 -> ZERO; else load |a| into quotient shift reg, |b| into divisor, rem=0, cnt=WIDTH -> RUN.
//  RUN: per cycle shift {rem,q} left 1; if rem>=|b| subtract, set q[0]=1; cnt--. Leave after WIDTH cycles -> FIX.
//  FIX: lo_out = sign_q ? -q : q; hi_out = sign_r ? -rem : rem (quotient truncates toward zero,
//   remainder takes sign of dividend) -> DONE.
//  DONE: div_stop=1 for exactly this cycle -> IDLE.
//  ZERO: div_stop=1 and div_zero=1 for this cycle; hi_out/lo_out keep previous values -> IDLE.
//  Latency: div_control sampled at edge N -> div_stop high during cycle N+WIDTH+2 (34 for WIDTH=32);
//   divide-by-zero -> div_stop/div_zero high during cycle N+1.
//  hi_out/lo_out change only in FIX and hold until the next completed division; valid when div_stop=1 and after.
//  Magnitude arithmetic is WIDTH+1 bits internally; |0x80000000| = 2^31 handled without overflow.
//  0x80000000 / -1: lo_out=0x80000000, hi_out=0 (wraps, no flag).
//  div_control while not IDLE: ignored, no queueing; a_in/b_in changes after start have no effect.
//  div_control held high across DONE: new operation starts only after returning to IDLE (next cycle).
//  Reset asserted mid-RUN: next cycle IDLE with all outputs 0; no div_stop pulse for the aborted op.
//  div_stop and div_zero never assert outside DONE/ZERO.
// TESTING
//  7 / 2 -> after 34 cycles div_stop pulse, lo=3, hi=1, div_zero=0.
//  -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); 7 / -2 -> lo=-3, hi=1.
//  0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; 0xFFFFFFFF / 0x7FFFFFFF -> lo=0, hi=-1.
//  any a / 0 with hi/lo preloaded (100/7 -> lo=14, hi=2) -> next cycle div_stop=div_zero=1, lo=14, hi=2 retained.
//  start 100/7, pulse div_control again at cycle 10 with different a_in/b_in -> single div_stop at cycle 34, lo=14, hi=2.
//  start, assert reset at cycle 15 -> outputs 0, no div_stop; fresh 9/3 afterwards -> lo=3, hi=0.

Source files
------------

// File: rtl/div_seq.sv
// Sequential signed divider with MIPS DIV semantics: restoring division on magnitudes,
// one quotient bit per clock, then sign fix-up into the HI (remainder) / LO (quotient) outputs.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_control,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero,
    output logic             div_stop
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FIX,
        DONE,
        ZERO
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [CW-1:0]    cnt_reg;
    logic             sign_q_reg;
    logic             sign_r_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             stop_reg;
    logic             zero_reg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             rem_fits;
    logic [WIDTH-1:0] rem_next;

    // Unsigned magnitudes: the most negative value maps onto 2^(WIDTH-1), which still fits.
    always_comb begin
        a_mag = a_in[WIDTH-1] ? -a_in : a_in;
        b_mag = b_in[WIDTH-1] ? -b_in : b_in;
    end

    // The shifted partial remainder needs one extra bit before the compare/subtract.
    always_comb begin
        rem_shift = {rem_reg, quot_reg[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, divisor_reg};
        rem_fits  = (rem_shift >= {1'b0, divisor_reg});
        rem_next  = WIDTH'(rem_fits ? rem_sub : rem_shift);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            rem_reg     <= '0;
            quot_reg    <= '0;
            divisor_reg <= '0;
            cnt_reg     <= '0;
            sign_q_reg  <= 1'b0;
            sign_r_reg  <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            stop_reg    <= 1'b0;
            zero_reg    <= 1'b0;
        end else begin
            stop_reg <= 1'b0;
            zero_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (div_control) begin
                        sign_q_reg <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        sign_r_reg <= a_in[WIDTH-1];
                        if (b_in == '0) begin
                            stop_reg  <= 1'b1;
                            zero_reg  <= 1'b1;
                            state_reg <= ZERO;
                        end else begin
                            quot_reg    <= a_mag;
                            divisor_reg <= b_mag;
                            rem_reg     <= '0;
                            cnt_reg     <= CW'(WIDTH);
                            state_reg   <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_reg  <= rem_next;
                    quot_reg <= {quot_reg[WIDTH-2:0], rem_fits};
                    cnt_reg  <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    // Quotient truncates toward zero; remainder follows the dividend's sign.
                    lo_reg    <= sign_q_reg ? -quot_reg : quot_reg;
                    hi_reg    <= sign_r_reg ? -rem_reg : rem_reg;
                    stop_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                DONE:    state_reg <= IDLE;
                ZERO:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign hi_out   = hi_reg;
    assign lo_out   = lo_reg;
    assign div_stop = stop_reg;
    assign div_zero = zero_reg;
endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed corner cases plus random divisions against a 64-bit arithmetic model.
module tb_div_seq;
    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             div_control;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_zero;
    logic             div_stop;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    div_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .div_control(div_control),
        .a_in(a_in),
        .b_in(b_in),
        .hi_out(hi_out),
        .lo_out(lo_out),
        .div_zero(div_zero),
        .div_stop(div_stop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
            $error("check %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: exact signed arithmetic in 64 bits, truncated back to 32.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        a_in        = a;
        b_in        = b;
        div_control = 1'b1;
        @(posedge clk);
        #1;
        div_control = 1'b0;
        a_in        = $urandom;
        b_in        = $urandom;
    endtask

    // Waits (bounded) for div_stop; n_io counts edges since the start edge.
    task automatic wait_stop(inout int n_io);
        while (div_stop !== 1'b1 && n_io < 200) begin
            @(posedge clk);
            #1;
            n_io++;
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq;
        logic [31:0] er;
        int n;
        start_op(a, b);
        n = 0;
        if (b == 32'd0) begin
            chk("zero_stop", {31'd0, div_stop}, 32'd1);
            chk("zero_flag", {31'd0, div_zero}, 32'd1);
            chk("zero_lo_hold", lo_out, exp_lo);
            chk("zero_hi_hold", hi_out, exp_hi);
        end else begin
            model(a, b, eq, er);
            wait_stop(n);
            chk("latency", n, LATENCY);
            chk("lo", lo_out, eq);
            chk("hi", hi_out, er);
            chk("no_zero_flag", {31'd0, div_zero}, 32'd0);
            exp_lo = eq;
            exp_hi = er;
        end
        @(posedge clk);
        #1;
        chk("stop_pulse_end", {31'd0, div_stop}, 32'd0);
        chk("zero_pulse_end", {31'd0, div_zero}, 32'd0);
        chk("lo_hold", lo_out, exp_lo);
        chk("hi_hold", hi_out, exp_hi);
        $display("div a=%h b=%h -> lo=%h hi=%h", a, b, lo_out, hi_out);
    endtask

    initial begin
        int n;
        int stray;
        int first_stop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset       = 1'b1;
        div_control = 1'b0;
        a_in        = '0;
        b_in        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_stop", {31'd0, div_stop}, 32'd0);
        chk("rst_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_div(32'd7, 32'd2);
        run_div(-32'd7, 32'd2);
        run_div(32'd7, -32'd2);
        run_div(32'h8000_0000, 32'hFFFF_FFFF);
        run_div(32'hFFFF_FFFF, 32'h7FFF_FFFF);
        run_div(32'h8000_0000, 32'h8000_0000);
        run_div(32'd100, 32'd7);
        run_div(32'd12345, 32'd0);

        // Second start request mid-operation must be ignored.
        start_op(32'd100, 32'd7);
        n = 1;
        repeat (8) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        a_in        = 32'd5;
        b_in        = 32'd0;
        div_control = 1'b1;
        @(posedge clk);
        #1;
        div_control = 1'b0;
        n = n;
        wait_stop(n);
        chk("ignored_start_latency", n, LATENCY);
        chk("ignored_start_lo", lo_out, 32'd14);
        chk("ignored_start_hi", hi_out, 32'd2);
        chk("ignored_start_zero", {31'd0, div_zero}, 32'd0);
        stray = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (div_stop === 1'b1) stray++;
        end
        chk("ignored_start_no_second_stop", stray, 0);
        $display("div a=00000064 b=00000007 with ignored restart -> lo=%h hi=%h", lo_out, hi_out);

        // div_control held high: back-to-back operations separated by one IDLE cycle.
        @(negedge clk);
        a_in        = 32'd100;
        b_in        = 32'd7;
        div_control = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        first_stop = -1;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (div_stop === 1'b1) begin
                if (first_stop < 0) first_stop = n;
                else break;
            end
        end
        div_control = 1'b0;
        chk("held_first_stop", first_stop, LATENCY);
        chk("held_second_stop", n, 2 * LATENCY + 2);
        chk("held_lo", lo_out, 32'd14);
        $display("div held start -> stops at %0d and %0d", first_stop, n);
        repeat (2) @(posedge clk);

        // Reset in the middle of an operation aborts it silently.
        start_op(32'd20, 32'd3);
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_lo", lo_out, 32'd0);
        chk("abort_hi", hi_out, 32'd0);
        chk("abort_stop", {31'd0, div_stop}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (div_stop === 1'b1) stray++;
        end
        chk("abort_no_stop", stray, 0);
        $display("div a=00000014 b=00000003 aborted by reset");
        exp_lo = '0;
        exp_hi = '0;
        run_div(32'd9, 32'd3);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 20);
                3:       rb = -$urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            run_div(ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
